// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared types and constants for the reset sequencer.
//   state_t     - sequencer states (2-bit encoding)
//   MIN_*       - smallest legal values of the sequencer parameters
//   cnt_width() - width of the shared hold/soft-pulse counter
`timescale 1ns/1ps
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASYNC = 2'd0,
        ST_HOLD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_SOFT  = 2'd3
    } state_t;

    localparam int unsigned MIN_SYNC_STAGES     = 2;
    localparam int unsigned MIN_HOLD_CYCLES     = 1;
    localparam int unsigned MIN_SOFT_RST_CYCLES = 1;

    // The counter never has to hold more than the longer of the two
    // phases, so size it for max(hold, soft) without wrap.
    function automatic int unsigned cnt_width(input int unsigned hold_cycles,
                                              input int unsigned soft_cycles);
        int unsigned longest;
        longest = (hold_cycles > soft_cycles) ? hold_cycles : soft_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// rst_sequencer_if: reset/status bundle between the sequencer and its user.
//   soft_rst_req  - level request for a software reset (rising edge acts)
//   async_rst_out - active-high reset for the flop stage's async input
//   sync_rst      - active-high reset for the flop stage's sync input
//   rst_done      - high while downstream logic is out of reset
// Modports: master = reset consumer / requester, slave = sequencer.
`timescale 1ns/1ps
interface rst_sequencer_if;

    logic soft_rst_req;
    logic async_rst_out;
    logic sync_rst;
    logic rst_done;

    modport master (
        output soft_rst_req,
        input  async_rst_out,
        input  sync_rst,
        input  rst_done
    );

    modport slave (
        input  soft_rst_req,
        output async_rst_out,
        output sync_rst,
        output rst_done
    );

endinterface

// File: rtl/rst_sync_chain.sv
// rst_sync_chain: reset synchronizer, asynchronous assert / synchronous
// deassert.
//   clk         - system clock
//   async_rst_n - raw active-low asynchronous reset
//   rst_sync_n  - synchronized active-low reset, rises SYNC_STAGES edges
//                 after async_rst_n goes high
`timescale 1ns/1ps
module rst_sync_chain #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic async_rst_n,
    output logic rst_sync_n
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = chain[SYNC_STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer: turns a raw board reset into the async and stretched sync
// resets of the flop stage, plus a software-requested sync-reset pulse.
//   clk         - system clock
//   async_rst_n - raw active-low asynchronous reset
//   bus         - slave side of rst_sequencer_if:
//                 soft_rst_req in; async_rst_out, sync_rst, rst_done out
// Out-of-range parameters are clamped to their smallest legal values.
`timescale 1ns/1ps
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned HOLD_CYCLES     = 8,
    parameter int unsigned SOFT_RST_CYCLES = 4
) (
    input  logic              clk,
    input  logic              async_rst_n,
    rst_sequencer_if.slave    bus
);

    localparam int unsigned SYNC_N = (SYNC_STAGES < MIN_SYNC_STAGES) ?
                                     MIN_SYNC_STAGES : SYNC_STAGES;
    localparam int unsigned HOLD_N = (HOLD_CYCLES < MIN_HOLD_CYCLES) ?
                                     MIN_HOLD_CYCLES : HOLD_CYCLES;
    localparam int unsigned SOFT_N = (SOFT_RST_CYCLES < MIN_SOFT_RST_CYCLES) ?
                                     MIN_SOFT_RST_CYCLES : SOFT_RST_CYCLES;
    localparam int unsigned CW     = cnt_width(HOLD_N, SOFT_N);

    // ST_HOLD is entered one edge after the chain releases (see ST_ASYNC),
    // so it runs one cycle short to keep sync_rst falling after
    // E(SYNC_STAGES + HOLD_CYCLES).
    localparam logic [CW-1:0] HOLD_LAST = CW'((HOLD_N >= 2) ? HOLD_N - 2 : 0);
    localparam logic [CW-1:0] SOFT_LAST = CW'(SOFT_N - 1);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic            req_q;
    logic            sync_rst_q;
    logic            rst_done_q;
    logic            rst_sync_n;

    rst_sync_chain #(
        .SYNC_STAGES (SYNC_N)
    ) u_sync_chain (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .rst_sync_n  (rst_sync_n)
    );

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state      <= ST_ASYNC;
            cnt        <= '0;
            req_q      <= 1'b0;
            sync_rst_q <= 1'b1;
            rst_done_q <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            req_q      <= bus.soft_rst_req;
            // Flags are registered from the next state so no input reaches
            // an output combinationally.
            sync_rst_q <= (state_next != ST_RUN);
            rst_done_q <= (state_next == ST_RUN);
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + CW'(1);
        unique case (state)
            ST_ASYNC: begin
                cnt_next = '0;
                // The chain output is seen here one edge after async_rst_out
                // has already fallen; a single-cycle hold is therefore fully
                // covered by that edge and goes straight to RUN.
                if (rst_sync_n) begin
                    state_next = (HOLD_N == 1) ? ST_RUN : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end
            end
            ST_RUN: begin
                cnt_next = '0;
                if (bus.soft_rst_req && !req_q) begin
                    state_next = ST_SOFT;
                end
            end
            ST_SOFT: begin
                if (cnt == SOFT_LAST) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_ASYNC;
                cnt_next   = '0;
            end
        endcase
    end

    assign bus.async_rst_out = ~rst_sync_n;
    assign bus.sync_rst      = sync_rst_q;
    assign bus.rst_done      = rst_done_q;

endmodule
